// File: rtl/handshake_rr_merge_if.sv
// Bundle of per-channel input handshakes, the merged output channel and FIFO status.
// The master modport is the producer/consumer side; the slave modport is the merge block.
interface handshake_rr_merge_if #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [CHW-1:0]       out_ch;
    logic                 out_ready;
    logic [NCH-1:0]       fifo_full;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch, fifo_full
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch, fifo_full
    );
endinterface

// File: rtl/handshake_rr_merge.sv
// N-to-1 valid/ready merge: one DEPTH-entry FIFO per input channel, drained
// round-robin into a single registered output beat tagged with its source channel.
module handshake_rr_merge #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    handshake_rr_merge_if.slave bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;

    logic [WIDTH-1:0] mem_q [NCH][DEPTH];
    logic [PW-1:0]    wr_ptr_q [NCH];
    logic [PW-1:0]    rd_ptr_q [NCH];

    logic [NCH-1:0]   full_w, empty_w, push_w, pop_w;
    logic             grant_vld, load_w;
    logic [CHW-1:0]   grant_ch, idx_c;
    int               idx;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [CHW-1:0]   out_ch_q, out_ch_d;
    logic [CHW-1:0]   rr_q, rr_d;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_comb begin
        full_w  = '0;
        empty_w = '0;
        for (int i = 0; i < NCH; i++) begin
            full_w[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                         (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
            empty_w[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
        end
    end

    // Descending scan so the channel nearest the RR pointer is the last (winning) write.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        idx       = 0;
        idx_c     = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = int'(rr_q) + k;
            if (idx >= NCH) idx = idx - NCH;
            idx_c = CHW'(idx);
            if (!empty_w[idx_c]) begin
                grant_vld = 1'b1;
                grant_ch  = idx_c;
            end
        end
    end

    assign load_w = grant_vld && (!out_valid_q || bus.out_ready);

    always_comb begin
        push_w = '0;
        pop_w  = '0;
        for (int i = 0; i < NCH; i++) begin
            push_w[i] = bus.in_valid[i] && !full_w[i];
            pop_w[i]  = load_w && (grant_ch == CHW'(i));
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_d        = rr_q;
        if (load_w) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[grant_ch][rd_ptr_q[grant_ch][AW-1:0]];
            out_ch_d    = grant_ch;
            rr_d        = (grant_ch == CHW'(NCH - 1)) ? '0 : grant_ch + CHW'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (push_w[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PW'(1);
                if (pop_w[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PW'(1);
            end
        end
    end

    // Storage is never read past the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (push_w[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_q        <= rr_d;
        end
    end

    assign bus.in_ready  = ~full_w;
    assign bus.fifo_full = full_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
endmodule

// File: tb/tb_handshake_rr_merge.sv
// Self-checking bench for handshake_rr_merge: directed scenarios plus random
// streaming, compared against a queue-based model of the merge.
module tb_handshake_rr_merge;
    localparam int W = 32;
    localparam int N = 4;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    handshake_rr_merge_if #(.WIDTH(W), .NCH(N)) bus();
    handshake_rr_merge #(.WIDTH(W), .NCH(N), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: per-channel queues of buffered beats, the output register, the RR pointer.
    logic [W-1:0] mq [N][$];
    logic [W-1:0] sb [N][$];
    bit           m_ov;
    logic [W-1:0] m_od;
    int           m_oc;
    int           m_rr;
    int           n_acc, n_hs;
    logic [W-1:0] log_d [$];
    int           log_c [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            sb[i].delete();
        end
        m_ov = 1'b0;
        m_od = '0;
        m_oc = 0;
        m_rr = 0;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() < D);
        return r;
    endfunction

    function automatic logic [N-1:0] m_full();
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() == D);
        return r;
    endfunction

    // One rising edge of the model, using the stimulus present before the edge.
    function automatic void model_edge();
        bit acc [N];
        bit found;
        int g;
        if (!rst) begin
            m_reset();
            return;
        end
        for (int i = 0; i < N; i++) acc[i] = bus.in_valid[i] && (mq[i].size() < D);
        found = 1'b0;
        g = 0;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (!found && mq[c].size() > 0) begin
                found = 1'b1;
                g = c;
            end
        end
        if (found && (!m_ov || bus.out_ready)) begin
            m_od = mq[g].pop_front();
            m_oc = g;
            m_ov = 1'b1;
            m_rr = (g + 1) % N;
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                mq[i].push_back(bus.in_data[i*W +: W]);
                sb[i].push_back(bus.in_data[i*W +: W]);
                n_acc++;
            end
        end
    endfunction

    task automatic compare_all();
        check("in_ready", bus.in_ready, m_ready());
        check("fifo_full", bus.fifo_full, m_full());
        check("out_valid", bus.out_valid, m_ov);
        if (m_ov) begin
            check("out_data", bus.out_data, m_od);
            check("out_ch", bus.out_ch, m_oc);
        end
    endtask

    task automatic step();
        bit hs, stall;
        logic [W-1:0] hd;
        int hc;
        hs    = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        stall = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b0);
        hd    = bus.out_data;
        hc    = int'(bus.out_ch);
        @(posedge clk);
        model_edge();
        if (hs && rst) begin
            n_hs++;
            log_d.push_back(hd);
            log_c.push_back(hc);
            if (sb[hc].size() == 0) check("sb_extra_beat", 1, 0);
            else check("sb_order", hd, sb[hc].pop_front());
        end
        @(negedge clk);
        compare_all();
        if (stall && rst) begin
            check("stall_data", bus.out_data, hd);
            check("stall_ch", bus.out_ch, hc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        m_reset();
        step();
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] val;
        bit pending, acc;

        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        n_acc = 0;
        n_hs  = 0;
        m_reset();

        // Reset held with random inputs.
        for (int k = 0; k < 4; k++) begin
            bus.in_valid  = N'($urandom);
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid = '0;
        rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_ch", bus.out_ch, 0);
        check("rst_in_ready", bus.in_ready, 4'hF);
        check("rst_fifo_full", bus.fifo_full, 0);
        @(negedge clk);

        // Single beat on channel 1.
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'b0010;
        bus.in_data   = '0;
        bus.in_data[1*W +: W] = 32'hDEADBEEF;
        step();
        bus.in_valid = '0;
        step();
        check("single_valid", bus.out_valid, 1);
        check("single_data", bus.out_data, 32'hDEADBEEF);
        check("single_ch", bus.out_ch, 1);
        step();
        check("single_clear", bus.out_valid, 0);

        // Backpressure: fill channel 0 while the consumer stalls.
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        val = 8'h10;
        for (int k = 0; k < 30 && val <= 8'h14; k++) begin
            bus.in_valid = 4'b0001;
            bus.in_data[W-1:0] = {24'h0, val};
            acc = (mq[0].size() < D);
            step();
            if (acc) val++;
        end
        check("bp_full", bus.fifo_full[0], 1);
        check("bp_in_ready", bus.in_ready[0], 0);
        check("bp_head", bus.out_data, 32'h10);
        bus.in_data[W-1:0] = 32'h15;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold", bus.in_ready[0], 0);
        end
        log_d.delete();
        log_c.delete();
        bus.out_ready = 1'b1;
        pending = 1'b1;
        for (int k = 0; k < 15; k++) begin
            bus.in_valid = pending ? 4'b0001 : 4'b0000;
            acc = pending && (mq[0].size() < D);
            step();
            if (acc) pending = 1'b0;
        end
        bus.in_valid = '0;
        check("bp_count", log_d.size(), 6);
        if (log_d.size() == 6)
            for (int k = 0; k < 6; k++) check("bp_order", log_d[k], 32'h10 + k);

        // Round-robin fairness with all channels backlogged.
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 4'hF;
            for (int c = 0; c < N; c++) bus.in_data[c*W +: W] = 32'h100 * c + k;
            step();
        end
        bus.in_valid = '0;
        step();
        log_d.delete();
        log_c.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            check("rr_valid", bus.out_valid, 1);
            step();
        end
        check("rr_drained", bus.out_valid, 0);
        check("rr_count", log_c.size(), 12);
        if (log_c.size() == 12)
            for (int k = 0; k < 12; k++) check("rr_order", log_c[k], k % N);

        // Random streaming on channels 0 and 2 with a toggling consumer.
        n_acc = 0;
        n_hs  = 0;
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = N'($urandom) & 4'b0101;
            bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 30; k++) step();
        check("stream_count", n_hs, n_acc);
        check("stream_sb0_empty", sb[0].size(), 0);
        check("stream_sb2_empty", sb[2].size(), 0);

        // Reset in mid-stream with beats buffered and the output register loaded.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 4'b0010;
            bus.in_data[1*W +: W] = 32'hA000 + k;
            step();
        end
        bus.in_valid = '0;
        check("mid_loaded", bus.out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        m_reset();
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_in_ready", bus.in_ready, 4'hF);
        check("mid_rst_full", bus.fifo_full, 0);
        step();
        step();
        rst = 1'b1;
        bus.in_valid = 4'b1001;
        bus.in_data[0*W +: W] = 32'hC0C0;
        bus.in_data[3*W +: W] = 32'hC3C3;
        step();
        bus.in_valid = '0;
        step();
        check("rr_restart_valid", bus.out_valid, 1);
        check("rr_restart_ch", bus.out_ch, 0);
        log_d.delete();
        log_c.delete();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("post_rst_count", log_d.size(), 2);
        if (log_d.size() == 2) begin
            check("post_rst_ch0", log_c[0], 0);
            check("post_rst_d0", log_d[0], 32'hC0C0);
            check("post_rst_ch1", log_c[1], 3);
            check("post_rst_d1", log_d[1], 32'hC3C3);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/handshake_rr_merge.md
Name: handshake_rr_merge

Overview:
- Parametrised N-to-1 merge for valid/ready handshake channels.
- Each of NCH input channels feeds its own DEPTH-entry FIFO. A round-robin arbiter drains the non-empty FIFOs into one registered output channel, tagged with the source channel index.
- Sits between multiple source-side handshake producers and a single drain-side consumer. It replaces point-to-point wiring where several producers share one consumer.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- NCH, 2, number of input channels (>=2).
- DEPTH, 4, entries per channel FIFO (power of 2, >=2).
- CHW, derived localparam = max(1, clog2(NCH)), width of the channel tag.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  NCH  per-channel valid; bit i belongs to channel i.
- in_data  input  NCH*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NCH  per-channel ready.
- out_valid  output  1  output beat valid.
- out_data  output  WIDTH  output payload.
- out_ch  output  CHW  index of the source channel of the current beat.
- out_ready  input  1  consumer ready.
- fifo_full  output  NCH  status: channel FIFO is holding DEPTH entries.

Behaviour:
- Reset (rst low, asynchronous assert; deassert is synchronised externally):
  - All FIFO read/write pointers = 0 and all FIFOs empty.
  - out_valid = 0, out_data = 0, out_ch = 0.
  - Round-robin pointer = 0.
  - in_ready = all ones (all FIFOs empty); fifo_full = 0.
  - Asserting reset mid-operation discards every buffered and in-flight beat. No beat is emitted after reset releases unless it is newly accepted.
- Input handshake:
  - A beat on channel i is accepted at a rising edge when in_valid[i] && in_ready[i].
  - in_ready[i] = !fifo_full[i]. It is derived only from registered pointers, so there is no combinational path from out_ready or in_valid.
  - A full FIFO deasserts in_ready even in a cycle where the same FIFO is being popped. There is no full-bypass.
  - Pointers are clog2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH. Full = MSBs differ and LSBs equal; empty = pointers equal.
- Output register:
  - Loads when (!out_valid || out_ready) and at least one FIFO is non-empty. The granted FIFO is popped on that same edge.
  - If no FIFO is non-empty, out_valid clears on an out_ready handshake.
  - While out_valid && !out_ready, out_valid, out_data and out_ch stay stable.
- Arbiter:
  - Grants the first non-empty channel searching upward from the RR pointer, wrapping at NCH-1 back to 0.
  - After a grant to channel g, the RR pointer = (g+1) mod NCH.
  - No grant means the pointer is unchanged.
- Latency and throughput:
  - A beat accepted on edge E into an empty system gives out_valid = 1 after edge E+1 (one cycle of buffering).
  - With out_ready held high and inputs backlogged, one beat is emitted per cycle.
- Ordering: beats from the same channel leave in acceptance order. There is no ordering guarantee across channels.
- Simultaneous events:
  - A push and a pop on the same FIFO in the same cycle are both performed; occupancy is unchanged.
  - Acceptance on several channels in the same cycle is independent per channel.
- Fairness: with all NCH FIFOs backlogged and out_ready high, the grant order is 0,1,...,NCH-1,0,... with no starvation.
- fifo_full[i] is registered-equivalent: a pure function of the pointers.

Test Plan:
- Reset check: hold rst low, drive random inputs, then release. Required: out_valid = 0, out_data = 0, out_ch = 0, in_ready = all ones, fifo_full = 0.
- Single beat: WIDTH = 32, NCH = 2. Push 0xDEADBEEF on ch1 at edge E with out_ready = 1. Required: out_valid = 1, out_data = 0xDEADBEEF, out_ch = 1 after edge E+1, then out_valid = 0 after edge E+2.
- Backpressure and full: out_ready = 0. Push 0x10..0x14 on ch0 (DEPTH = 4).
  - Required: 0x10 enters the output register; 0x11..0x14 fill the FIFO; fifo_full[0] = 1 and in_ready[0] = 0.
  - Beat 0x15 is held until out_ready rises.
  - Output order is 0x10,0x11,...,0x15 with no loss or duplication.
- Round-robin: NCH = 4, all channels pre-filled with 3 beats each, then out_ready = 1. Required: out_ch sequence 0,1,2,3,0,1,2,3,0,1,2,3 with 12 consecutive valid cycles.
- Stall stability: toggle out_ready pseudo-randomly while streaming on 2 channels. Required:
  - out_data and out_ch are constant whenever out_valid && !out_ready.
  - A scoreboard confirms per-channel ordering and exact beat count.
- Reset mid-stream: assert rst with 3 beats buffered and out_valid = 1. Required:
  - Immediate out_valid = 0.
  - After release, only beats accepted post-reset appear.
  - The RR pointer restarts at channel 0.
